seg7_scan_decoder: RTL and testbench

//  Passive reader of the multiplexed 8-digit seven-segment bus (SEG/AN), built as the decode side of
//  the temperature display driver. Watches the active-low anode/segment lines, captures each digit

---
 rtl/seg7_scan_decoder_if.sv | 16 +
 rtl/seg7_scan_decoder.sv | 249 ++++++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_decoder_if.sv
// Seven-segment scan bus: active-low anodes and segments.
// master drives the display lines; slave only observes them.
interface seg7_scan_decoder_if;
    logic [6:0] SEG;
    logic [7:0] AN;

    modport master (
        output SEG,
        output AN
    );

    modport slave (
        input SEG,
        input AN
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Passive decoder for the multiplexed 8-digit seven-segment bus.
// Ports: clk_25MHz, reset (async, high), bus (SEG/AN slave),
// c_data/f_data (last good values), frame_valid/frame_err pulses,
// err_code (0 ok, 1 pattern, 2 layout, 3 timeout).
module seg7_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input  logic               clk_25MHz,
    input  logic               reset,
    seg7_scan_decoder_if.slave bus,
    output logic [7:0]         c_data,
    output logic [7:0]         f_data,
    output logic               frame_valid,
    output logic               frame_err,
    output logic [1:0]         err_code
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SW-1:0] SETTLE_HIT = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_SAT = SW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TO_HIT     = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] SYM_DEG = 4'd10;
    localparam logic [3:0] SYM_C   = 4'd11;
    localparam logic [3:0] SYM_F   = 4'd12;
    localparam logic [3:0] SYM_BAD = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        CHECK
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]    an_prev;
    logic [6:0]    seg_prev;
    logic [SW-1:0] settle_cnt;
    logic          changed;

    logic [3:0] zeros;
    logic [2:0] an_idx;
    logic       an_ok;

    logic [3:0] seg_sym;
    logic       seg_ok;

    logic       cap;
    logic [7:0] cap_mask;
    logic [7:0] bitmap;
    logic [3:0] slot_sym [8];
    logic [7:0] slot_ok;

    logic [TW-1:0] tcnt;
    logic          timeout;

    logic       all_ok;
    logic       layout_ok;
    logic [7:0] c_val;
    logic [7:0] f_val;

    logic [7:0] c_d;
    logic [7:0] f_d;
    logic       fv_d;
    logic       fe_d;
    logic [1:0] code_d;

    // 10*t + u built from shifts: 8t + 2t + u.
    function automatic logic [7:0] tens_units(
        input logic [3:0] t,
        input logic [3:0] u
    );
        return {1'b0, t, 3'b000} + {3'b000, t, 1'b0} + {4'b0000, u};
    endfunction

    // Anode decode: valid only with exactly one low line.
    always_comb begin
        zeros  = 4'd0;
        an_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!bus.AN[i]) begin
                zeros  = zeros + 4'd1;
                an_idx = i[2:0];
            end
        end
        an_ok = (zeros == 4'd1);
    end

    always_comb begin
        seg_ok  = 1'b1;
        seg_sym = SYM_BAD;
        case (bus.SEG)
            7'b0000001: seg_sym = 4'd0;
            7'b1001111: seg_sym = 4'd1;
            7'b0010010: seg_sym = 4'd2;
            7'b0000110: seg_sym = 4'd3;
            7'b1001100: seg_sym = 4'd4;
            7'b0100100: seg_sym = 4'd5;
            7'b0100000: seg_sym = 4'd6;
            7'b0001111: seg_sym = 4'd7;
            7'b0000000: seg_sym = 4'd8;
            7'b0000100: seg_sym = 4'd9;
            7'b0011100: seg_sym = SYM_DEG;
            7'b0110001: seg_sym = SYM_C;
            7'b0111000: seg_sym = SYM_F;
            default:    seg_ok  = 1'b0;
        endcase
    end

    assign changed = (bus.AN != an_prev) || (bus.SEG != seg_prev);

    // Saturating one past the hit value keeps a long dwell
    // from capturing again once the next frame has begun.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            an_prev    <= 8'hFF;
            seg_prev   <= 7'h7F;
            settle_cnt <= '0;
        end else begin
            an_prev  <= bus.AN;
            seg_prev <= bus.SEG;
            if (changed)
                settle_cnt <= '0;
            else if (settle_cnt != SETTLE_SAT)
                settle_cnt <= settle_cnt + 1'b1;
        end
    end

    assign cap = !changed && (settle_cnt == SETTLE_HIT) && an_ok &&
                 !bitmap[an_idx] && (state != CHECK);

    assign cap_mask = cap ? (8'd1 << an_idx) : 8'd0;

    assign timeout = (state == COLLECT) && (tcnt == TO_HIT) && !cap;

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if ((state != COLLECT) || cap) begin
            tcnt <= '0;
        end else if (!timeout) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            bitmap  <= 8'h00;
            slot_ok <= 8'h00;
            for (int i = 0; i < 8; i++)
                slot_sym[i] <= 4'd0;
        end else if ((state == CHECK) || timeout) begin
            bitmap <= 8'h00;
        end else if (cap) begin
            bitmap[an_idx]   <= 1'b1;
            slot_sym[an_idx] <= seg_sym;
            slot_ok[an_idx]  <= seg_ok;
        end
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cap)
                    state_nxt = COLLECT;
            end
            COLLECT: begin
                if ((bitmap | cap_mask) == 8'hFF)
                    state_nxt = CHECK;
                else if (timeout)
                    state_nxt = IDLE;
            end
            CHECK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign all_ok = &slot_ok;

    assign layout_ok = (slot_sym[0] == SYM_C)   &&
                       (slot_sym[1] == SYM_DEG) &&
                       (slot_sym[4] == SYM_F)   &&
                       (slot_sym[5] == SYM_DEG) &&
                       (slot_sym[2] < 4'd10)    &&
                       (slot_sym[3] < 4'd10)    &&
                       (slot_sym[6] < 4'd10)    &&
                       (slot_sym[7] < 4'd10);

    assign c_val = tens_units(slot_sym[3], slot_sym[2]);
    assign f_val = tens_units(slot_sym[7], slot_sym[6]);

    always_comb begin
        c_d    = c_data;
        f_d    = f_data;
        code_d = err_code;
        fv_d   = 1'b0;
        fe_d   = 1'b0;
        if (timeout) begin
            fe_d   = 1'b1;
            code_d = 2'd3;
        end else if (state == CHECK) begin
            if (!all_ok) begin
                fe_d   = 1'b1;
                code_d = 2'd1;
            end else if (!layout_ok) begin
                fe_d   = 1'b1;
                code_d = 2'd2;
            end else begin
                fv_d   = 1'b1;
                code_d = 2'd0;
                c_d    = c_val;
                f_d    = f_val;
            end
        end
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            c_data      <= 8'd0;
            f_data      <= 8'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            c_data      <= c_d;
            f_data      <= f_d;
            frame_valid <= fv_d;
            frame_err   <= fe_d;
            err_code    <= code_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder.
// Drives scan frames on the bus and checks decoded results.
module tb_seg7_scan_decoder;

    localparam int SETTLE = 16;
    localparam int TOUT   = 2000;
    localparam int DWELL  = 40;

    localparam logic [6:0] P_C   = 7'b0110001;
    localparam logic [6:0] P_F   = 7'b0111000;
    localparam logic [6:0] P_DEG = 7'b0011100;

    logic       clk_25MHz = 1'b0;
    logic       reset;
    logic [7:0] c_data;
    logic [7:0] f_data;
    logic       frame_valid;
    logic       frame_err;
    logic [1:0] err_code;

    always #20 clk_25MHz = ~clk_25MHz;

    seg7_scan_decoder_if bus ();

    seg7_scan_decoder #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk_25MHz   (clk_25MHz),
        .reset       (reset),
        .bus         (bus),
        .c_data      (c_data),
        .f_data      (f_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_code    (err_code)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int nv    = 0;
    int ne    = 0;

    logic [6:0] slots [8];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk_25MHz) begin
        if (!reset) begin
            if (frame_valid)
                nv++;
            if (frame_err)
                ne++;
            if (frame_valid || frame_err)
                check("excl", int'(frame_valid & frame_err), 0);
        end
    end

    function automatic logic [6:0] dig(input int n);
        case (n)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    task automatic build(input int c, input int f);
        slots[0] = P_C;
        slots[1] = P_DEG;
        slots[2] = dig(c % 10);
        slots[3] = dig(c / 10);
        slots[4] = P_F;
        slots[5] = P_DEG;
        slots[6] = dig(f % 10);
        slots[7] = dig(f / 10);
    endtask

    task automatic show(input int idx, input logic [6:0] s, input int cyc);
        bus.AN  = ~(8'd1 << idx);
        bus.SEG = s;
        repeat (cyc) @(negedge clk_25MHz);
    endtask

    task automatic blank(input int cyc);
        bus.AN  = 8'hFF;
        bus.SEG = 7'h7F;
        repeat (cyc) @(negedge clk_25MHz);
    endtask

    task automatic send(input bit rev);
        int k;
        for (int i = 0; i < 8; i++) begin
            k = rev ? 7 - i : i;
            show(k, slots[k], DWELL);
        end
        blank(10);
    endtask

    task automatic clr_cnt();
        @(negedge clk_25MHz);
        nv = 0;
        ne = 0;
    endtask

    initial begin
        bus.AN  = 8'hFF;
        bus.SEG = 7'h7F;
        reset   = 1'b1;
        repeat (3) @(negedge clk_25MHz);
        check("rst_c", c_data, 0);
        check("rst_f", f_data, 0);
        check("rst_fv", frame_valid, 0);
        check("rst_fe", frame_err, 0);
        check("rst_code", err_code, 0);
        reset = 1'b0;
        blank(5);

        // 25C / 77F in order 0..7
        clr_cnt();
        build(25, 77);
        send(1'b0);
        check("t1_nv", nv, 1);
        check("t1_ne", ne, 0);
        check("t1_c", c_data, 25);
        check("t1_f", f_data, 77);
        check("t1_code", err_code, 0);

        // invalid pattern in slot 2
        clr_cnt();
        build(25, 77);
        slots[2] = 7'b1111111;
        send(1'b0);
        check("t2_nv", nv, 0);
        check("t2_ne", ne, 1);
        check("t2_code", err_code, 1);
        check("t2_c", c_data, 25);

        // F where C belongs
        clr_cnt();
        build(25, 77);
        slots[0] = P_F;
        send(1'b0);
        check("t3_ne", ne, 1);
        check("t3_code", err_code, 2);
        check("t3_f", f_data, 77);

        // partial frame then timeout
        clr_cnt();
        build(11, 22);
        for (int i = 0; i < 5; i++)
            show(i, slots[i], DWELL);
        blank(TOUT + 10);
        check("t4_ne", ne, 1);
        check("t4_nv", nv, 0);
        check("t4_code", err_code, 3);
        check("t4_c", c_data, 25);
        clr_cnt();
        build(30, 86);
        send(1'b0);
        check("t4b_nv", nv, 1);
        check("t4b_c", c_data, 30);
        check("t4b_f", f_data, 86);
        check("t4b_code", err_code, 0);

        // glitches and a two-anode blank, reverse scan order
        clr_cnt();
        build(42, 57);
        bus.AN  = 8'hFC;
        bus.SEG = dig(8);
        repeat (DWELL) @(negedge clk_25MHz);
        for (int i = 7; i >= 0; i--) begin
            if (i == 3)
                show(3, dig(9), SETTLE - 2);
            show(i, slots[i], DWELL);
        end
        blank(10);
        check("t5_nv", nv, 1);
        check("t5_ne", ne, 0);
        check("t5_c", c_data, 42);
        check("t5_f", f_data, 57);

        // reset mid-frame
        clr_cnt();
        build(0, 32);
        for (int i = 0; i < 4; i++)
            show(i, slots[i], DWELL);
        reset = 1'b1;
        #1;
        check("t6_rst_c", c_data, 0);
        check("t6_rst_f", f_data, 0);
        check("t6_rst_code", err_code, 0);
        bus.AN  = 8'hFF;
        bus.SEG = 7'h7F;
        repeat (2) @(negedge clk_25MHz);
        reset = 1'b0;
        blank(TOUT + 10);
        check("t6_ne", ne, 0);
        clr_cnt();
        send(1'b0);
        check("t6_nv", nv, 1);
        check("t6_c", c_data, 0);
        check("t6_f", f_data, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
